// File: rtl/seven_seg_pkg.sv
// Shared constants and types for seven-segment receive-side logic.
// Segment bytes are {a,b,c,d,e,f,g,dp}, 1 = lit.
package seven_seg_pkg;

    localparam logic [7:0] SEG_0     = 8'b1111_1100;
    localparam logic [7:0] SEG_1     = 8'b0110_0000;
    localparam logic [7:0] SEG_2     = 8'b1101_1010;
    localparam logic [7:0] SEG_3     = 8'b1111_0010;
    localparam logic [7:0] SEG_4     = 8'b0110_0110;
    localparam logic [7:0] SEG_5     = 8'b1011_0110;
    localparam logic [7:0] SEG_6     = 8'b1011_1110;
    localparam logic [7:0] SEG_7     = 8'b1110_0000;
    localparam logic [7:0] SEG_8     = 8'b1111_1110;
    localparam logic [7:0] SEG_9     = 8'b1111_0110;
    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

    localparam logic [3:0] BLANK_CODE   = 4'hF;
    localparam logic [3:0] INVALID_CODE = 4'hE;

    typedef enum logic [1:0] {
        SETTLE  = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } cap_state_e;

endpackage

// File: rtl/seven_seg_to_bcd.sv
// Combinational decode of a 7-bit a..g pattern back to a BCD code.
// Blank decodes to BLANK_CODE without error; unknown patterns flag err.
module seven_seg_to_bcd
    import seven_seg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [6:0]       seg,
    output logic [WIDTH-1:0] code,
    output logic             err
);

    always_comb begin
        code = WIDTH'(INVALID_CODE);
        err  = 1'b1;
        case (seg)
            SEG_0[7:1]:     begin code = WIDTH'(0); err = 1'b0; end
            SEG_1[7:1]:     begin code = WIDTH'(1); err = 1'b0; end
            SEG_2[7:1]:     begin code = WIDTH'(2); err = 1'b0; end
            SEG_3[7:1]:     begin code = WIDTH'(3); err = 1'b0; end
            SEG_4[7:1]:     begin code = WIDTH'(4); err = 1'b0; end
            SEG_5[7:1]:     begin code = WIDTH'(5); err = 1'b0; end
            SEG_6[7:1]:     begin code = WIDTH'(6); err = 1'b0; end
            SEG_7[7:1]:     begin code = WIDTH'(7); err = 1'b0; end
            SEG_8[7:1]:     begin code = WIDTH'(8); err = 1'b0; end
            SEG_9[7:1]:     begin code = WIDTH'(9); err = 1'b0; end
            SEG_BLANK[7:1]: begin code = WIDTH'(BLANK_CODE); err = 1'b0; end
            default:        begin code = WIDTH'(INVALID_CODE); err = 1'b1; end
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_capture.sv
// Watches a multiplexed seven-segment bus, debounces each digit dwell,
// decodes it and publishes one packed DEPTH-digit frame per full scan.
module seven_seg_scan_capture
    import seven_seg_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 8,
    parameter int STABLE = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             seg_in,
    input  logic [DEPTH-1:0]       dig_sel,
    output logic [WIDTH*DEPTH-1:0] data_out,
    output logic [DEPTH-1:0]       dp_out,
    output logic                   frame_valid,
    output logic                   frame_err
);

    localparam int CW = $clog2(STABLE + 1);
    localparam int PW = 8 + DEPTH;
    localparam logic [CW-1:0]          CNT_MAX    = CW'(STABLE);
    localparam logic [WIDTH-1:0]       BLANK_NIB  = WIDTH'(BLANK_CODE);
    localparam logic [WIDTH*DEPTH-1:0] BLANK_WORD = {DEPTH{BLANK_NIB}};

    function automatic logic is_onehot(input logic [DEPTH-1:0] v);
        return (v != '0) && ((v & (v - DEPTH'(1))) == '0);
    endfunction

    logic [PW-1:0]          pair_d, pair_q;
    logic [CW-1:0]          cnt_d, cnt_q;
    cap_state_e             state_d, state_q;
    logic [DEPTH-1:0]       seen_d, seen_q;
    logic                   err_acc_d, err_acc_q;
    logic [WIDTH*DEPTH-1:0] shadow_d, shadow_q;
    logic [DEPTH-1:0]       shadow_dp_d, shadow_dp_q;
    logic [WIDTH*DEPTH-1:0] data_d, data_q;
    logic [DEPTH-1:0]       dp_d, dp_q;
    logic                   fv_d, fv_q;
    logic                   ferr_d, ferr_q;

    logic [7:0]             seg_q;
    logic [DEPTH-1:0]       sel_q;
    logic [WIDTH-1:0]       dec_code;
    logic                   dec_err;
    logic                   same;
    logic                   capture;
    logic                   frame_done;

    assign seg_q = pair_q[PW-1:DEPTH];
    assign sel_q = pair_q[DEPTH-1:0];

    // Capture decodes the registered pair, which is the value that was debounced.
    seven_seg_to_bcd #(.WIDTH(WIDTH)) u_dec (
        .seg  (seg_q[7:1]),
        .code (dec_code),
        .err  (dec_err)
    );

    always_comb begin
        pair_d = {seg_in, dig_sel};
        same   = (pair_d == pair_q);

        cnt_d = CW'(1);
        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        end

        // Entering CAPTURE on the edge where the count reaches STABLE makes
        // the write land exactly STABLE edges after the pair first appeared.
        state_d = state_q;
        case (state_q)
            SETTLE:  if (same && (cnt_d == CNT_MAX) && is_onehot(dig_sel)) state_d = CAPTURE;
            CAPTURE: state_d = HOLD;
            HOLD:    state_d = HOLD;
            default: state_d = SETTLE;
        endcase
        if (!same) begin
            state_d = SETTLE;
        end
    end

    always_comb begin
        capture    = (state_q == CAPTURE);
        frame_done = &seen_q;

        // A capture coinciding with frame completion seeds the next frame.
        seen_d    = frame_done ? '0   : seen_q;
        err_acc_d = frame_done ? 1'b0 : err_acc_q;
        if (capture) begin
            seen_d    = seen_d | sel_q;
            err_acc_d = err_acc_d | dec_err;
        end

        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        for (int k = 0; k < DEPTH; k++) begin
            if (capture && sel_q[k]) begin
                shadow_d[k*WIDTH +: WIDTH] = dec_code;
                shadow_dp_d[k]             = seg_q[0];
            end
        end

        data_d = frame_done ? shadow_q    : data_q;
        dp_d   = frame_done ? shadow_dp_q : dp_q;
        ferr_d = frame_done ? err_acc_q   : ferr_q;
        fv_d   = frame_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q      <= '0;
            cnt_q       <= '0;
            state_q     <= SETTLE;
            seen_q      <= '0;
            err_acc_q   <= 1'b0;
            shadow_q    <= BLANK_WORD;
            shadow_dp_q <= '0;
            data_q      <= BLANK_WORD;
            dp_q        <= '0;
            fv_q        <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            pair_q      <= pair_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            seen_q      <= seen_d;
            err_acc_q   <= err_acc_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            data_q      <= data_d;
            dp_q        <= dp_d;
            fv_q        <= fv_d;
            ferr_q      <= ferr_d;
        end
    end

    assign data_out    = data_q;
    assign dp_out      = dp_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;

endmodule
